i2s_encoder_multi: RTL and testbench
====================================

Name: i2s_encoder_multi

Overview:
- Parametrised successor to the fixed 16-bit stereo I2S encoder.
- Serialises one stereo sample pair per frame onto BCLK/LRCLK/SDATA, all derived from the master clock.
- Adds the following:
  - configurable sample width, slot width and BCLK divider;
  - run-time format select: I2S, left-justified or right-justified;
  - a per-frame load strobe with valid/underrun handshake.
- Sits between the audio sample source (e.g. AD1868 data path) and the external DAC pins.

Parameters:
- DATA_WIDTH, 16: sample bits per channel; range 8..32.
- SLOT_WIDTH, 32: BCLK periods per channel slot; must be >= DATA_WIDTH.
- BCLK_DIV, 4: mclk cycles per BCLK period; even, >= 2.

Ports:
- i_mclk  in  1  master clock; all logic is on its rising edge.
- i_rst_x  in  1  asynchronous active-low reset.
- i_data_l  in  DATA_WIDTH  left sample, two's complement; sampled only when o_load=1.
- i_data_r  in  DATA_WIDTH  right sample; sampled only when o_load=1.
- i_valid  in  1  sample pair valid; sampled only when o_load=1.
- i_format  in  2  0=I2S, 1=left-justified, 2=right-justified, 3=reserved (treated as 0); sampled only when o_load=1.
- o_load  out  1  one-mclk pulse: inputs are captured on this cycle.
- o_underrun  out  1  one-mclk pulse coincident with o_load when i_valid=0.
- o_bclk  out  1  bit clock.
- o_lrclk  out  1  word select.
- o_sdata  out  1  serial data, MSB first.

Behaviour:
- Reset (async, i_rst_x=0), all outputs and registers go to 0:
  - div_cnt=0, bit_cnt=0, shift data=0, format=I2S;
  - o_bclk=0, o_lrclk=0, o_sdata=0, o_load=0, o_underrun=0.
- Reset mid-frame aborts the frame immediately; no partial-state recovery.
- Release of reset is synchronised by design; the first rising edge after release starts counting.
- Counters:
  - div_cnt counts 0..BCLK_DIV-1, wrapping.
  - bit_cnt (0..2*SLOT_WIDTH-1) increments when div_cnt wraps to 0, and itself wraps.
  - Slot position p = bit_cnt mod SLOT_WIDTH. Left slot: bit_cnt < SLOT_WIDTH.
- o_bclk is registered: 0 while div_cnt < BCLK_DIV/2, else 1. Data and LRCLK change only on the cycle div_cnt becomes 0 (BCLK falling edge), so they are stable across the rising edge.
- Load:
  - o_load=1 on the single cycle where div_cnt=BCLK_DIV-1 and bit_cnt=2*SLOT_WIDTH-1.
  - On that edge, i_data_l/i_data_r/i_format are captured if i_valid=1.
  - If i_valid=0, both captured samples are 0 (format still captured) and o_underrun=1 the same cycle.
  - New data drives o_sdata from the next cycle (bit_cnt=0).
- First frame after reset transmits zeros; the first o_load occurs 2*SLOT_WIDTH*BCLK_DIV-1 cycles after reset release.
- Left-justified (LJ) stream, per slot:
  - p < DATA_WIDTH: data[DATA_WIDTH-1-p]; otherwise 0.
  - o_lrclk=1 in left slot, 0 in right slot.
- Right-justified (RJ):
  - p >= SLOT_WIDTH-DATA_WIDTH: data[SLOT_WIDTH-1-p]; otherwise 0.
  - o_lrclk as LJ.
- I2S:
  - o_sdata = LJ stream delayed by exactly one BCLK period (BCLK_DIV mclk cycles) via a one-bit delay register.
  - o_lrclk=0 in left slot, 1 in right slot, not delayed.
  - The final bit of the right slot therefore appears at bit_cnt=0 of the next frame.
- SLOT_WIDTH==DATA_WIDTH: LJ and RJ are identical; no pad bits.
- Format change takes effect only at a frame boundary. In I2S, the delayed bit crossing that boundary is whatever the previous format produced.
- Simultaneous events: o_load and o_underrun coincide by definition. Input changes outside o_load have no effect.

Test Plan:
- DATA_WIDTH=16, SLOT_WIDTH=16, BCLK_DIV=4, format=0, L=16'hF0F0, R=16'h0F0F, valid=1 → o_load every 128 mclk; o_bclk period 4 mclk; o_lrclk low 64/high 64 mclk; second frame sdata = 1 delayed bit then 1111000011110000 then 0000111100001111.
- Same data, format=1 → o_lrclk high in left slot; MSB of 16'hF0F0 on bit_cnt=0 with no delay.
- DATA_WIDTH=16, SLOT_WIDTH=32, format=2, L=16'h8001 → left slot: 16 zeros then 1000000000000001. format=1 → 1000000000000001 then 16 zeros.
- i_valid=0 at an o_load → o_underrun single-cycle pulse; next frame all sdata=0; o_bclk/o_lrclk uninterrupted.
- i_format changed 1→0 mid-frame → current frame stays LJ; I2S polarity/delay starts exactly at next bit_cnt=0.
- Assert i_rst_x=0 mid-frame → all outputs 0 immediately (async); after release, first o_load after 2*SLOT_WIDTH*BCLK_DIV-1 cycles.

Source files
------------

// File: rtl/i2s_encoder_multi_if.sv
// Sample-side and pin-side signals of the multi-format I2S encoder.
// The sample source takes the master modport; the encoder takes the slave modport.
interface i2s_encoder_multi_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_data_l;
    logic [DATA_WIDTH-1:0] i_data_r;
    logic                  i_valid;
    logic [1:0]            i_format;
    logic                  o_load;
    logic                  o_underrun;
    logic                  o_bclk;
    logic                  o_lrclk;
    logic                  o_sdata;

    modport master (
        output i_data_l, i_data_r, i_valid, i_format,
        input  o_load, o_underrun, o_bclk, o_lrclk, o_sdata
    );

    modport slave (
        input  i_data_l, i_data_r, i_valid, i_format,
        output o_load, o_underrun, o_bclk, o_lrclk, o_sdata
    );
endinterface

// File: rtl/i2s_encoder_multi.sv
// Stereo serialiser with run-time I2S / left-justified / right-justified framing.
// BCLK, LRCLK and SDATA are all registered and derived from i_mclk.
module i2s_encoder_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic               i_mclk,
    input  logic               i_rst_x,
    i2s_encoder_multi_if.slave bus
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_WIDTH);

    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_RJ  = 2'd2
    } fmt_t;

    logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_l_reg, data_l_next;
    logic [DATA_WIDTH-1:0] data_r_reg, data_r_next;
    fmt_t                  fmt_reg, fmt_next;
    logic                  bclk_reg, bclk_next;
    logic                  lrclk_reg, lrclk_next;
    logic                  sdata_reg, sdata_next;
    logic                  stream_reg, stream_next;

    logic                  div_wrap;
    logic                  load;
    logic                  slot_left;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] bit_sel;
    logic                  stream_bit;
    int                    pos;

    // Counters and capture; everything downstream looks at the state being entered.
    always_comb begin
        div_wrap     = (div_cnt_reg == DIV_LAST);
        load         = div_wrap && (bit_cnt_reg == BIT_LAST);
        div_cnt_next = div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
        bit_cnt_next = bit_cnt_reg;
        if (div_wrap) begin
            bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
        end
        data_l_next = data_l_reg;
        data_r_next = data_r_reg;
        fmt_next    = fmt_reg;
        if (load) begin
            data_l_next = bus.i_valid ? bus.i_data_l : '0;
            data_r_next = bus.i_valid ? bus.i_data_r : '0;
            fmt_next    = (bus.i_format == 2'd3) ? FMT_I2S : fmt_t'(bus.i_format);
        end
        slot_left = (bit_cnt_next < SLOT_SIZE);
        word      = slot_left ? data_l_next : data_r_next;
        pos       = slot_left ? int'(bit_cnt_next) : int'(bit_cnt_next) - SLOT_WIDTH;
    end

    // One-hot select of the sample bit for this slot position (none in pad positions).
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sel
            assign bit_sel[gi] = (fmt_next == FMT_RJ) ? (pos == SLOT_WIDTH - 1 - gi)
                                                      : (pos == DATA_WIDTH - 1 - gi);
        end
    endgenerate

    assign stream_bit = |(word & bit_sel);

    // stream_reg holds the undelayed bit, which also serves as the I2S one-BCLK delay.
    always_comb begin
        bclk_next   = (div_cnt_next >= DIV_HALF);
        stream_next = stream_reg;
        lrclk_next  = lrclk_reg;
        sdata_next  = sdata_reg;
        if (div_wrap) begin
            stream_next = stream_bit;
            lrclk_next  = slot_left ^ (fmt_next == FMT_I2S);
            sdata_next  = (fmt_next == FMT_I2S) ? stream_reg : stream_bit;
        end
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            data_l_reg  <= '0;
            data_r_reg  <= '0;
            fmt_reg     <= FMT_I2S;
            bclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
            sdata_reg   <= 1'b0;
            stream_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            data_l_reg  <= data_l_next;
            data_r_reg  <= data_r_next;
            fmt_reg     <= fmt_next;
            bclk_reg    <= bclk_next;
            lrclk_reg   <= lrclk_next;
            sdata_reg   <= sdata_next;
            stream_reg  <= stream_next;
        end
    end

    assign bus.o_load     = load;
    assign bus.o_underrun = load & ~bus.i_valid;
    assign bus.o_bclk     = bclk_reg;
    assign bus.o_lrclk    = lrclk_reg;
    assign bus.o_sdata    = sdata_reg;
endmodule

// File: tb/tb_i2s_encoder_multi.sv
// Two encoder instances (slot == sample width, and wide slot with a different divider)
// compared cycle by cycle against a frame-level model of the serial stream.
module tb_i2s_encoder_multi;
    localparam int DW  = 16;
    localparam int SW0 = 16;
    localparam int D0  = 4;
    localparam int SW1 = 32;
    localparam int D1  = 6;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] tb_l;
    logic [DW-1:0] tb_r;
    logic          tb_valid;
    logic [1:0]    tb_fmt;

    int total = 0;
    int bad   = 0;

    i2s_encoder_multi_if #(.DATA_WIDTH(DW)) bus0 ();
    i2s_encoder_multi_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.i_data_l = tb_l;
    assign bus0.i_data_r = tb_r;
    assign bus0.i_valid  = tb_valid;
    assign bus0.i_format = tb_fmt;
    assign bus1.i_data_l = tb_l;
    assign bus1.i_data_r = tb_r;
    assign bus1.i_valid  = tb_valid;
    assign bus1.i_format = tb_fmt;

    i2s_encoder_multi #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW0), .BCLK_DIV(D0)) dut0 (
        .i_mclk  (clk),
        .i_rst_x (rst_n),
        .bus     (bus0)
    );

    i2s_encoder_multi #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW1), .BCLK_DIV(D1)) dut1 (
        .i_mclk  (clk),
        .i_rst_x (rst_n),
        .bus     (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Undelayed bit of a slot stream: LJ for formats 0/1, RJ for format 2.
    function automatic logic model_bit(int sw, logic [DW-1:0] l, logic [DW-1:0] r,
                                       logic [1:0] f, int b);
        logic [DW-1:0] w;
        logic [DW-1:0] sh;
        int            p;
        w = (b < sw) ? l : r;
        p = b % sw;
        if (f == 2'd2) begin
            if (p < sw - DW) return 1'b0;
            sh = w >> (sw - 1 - p);
        end else begin
            if (p >= DW) return 1'b0;
            sh = w >> (DW - 1 - p);
        end
        return sh[0];
    endfunction

    function automatic logic [31:0] obs(int i);
        if (i == 0)
            return {27'b0, bus0.o_load, bus0.o_underrun, bus0.o_bclk, bus0.o_lrclk, bus0.o_sdata};
        return {27'b0, bus1.o_load, bus1.o_underrun, bus1.o_bclk, bus1.o_lrclk, bus1.o_sdata};
    endfunction

    // Reference model: n = mclk edges since reset release, one frame record per instance.
    int            n        [2];
    logic [DW-1:0] cur_l    [2];
    logic [DW-1:0] cur_r    [2];
    logic [1:0]    cur_f    [2];
    logic          prev_last[2];

    initial begin
        int          sw, d, dv, b;
        logic        ld, i2s, left, sd;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    n[i]         = 0;
                    cur_l[i]     = '0;
                    cur_r[i]     = '0;
                    cur_f[i]     = 2'd0;
                    prev_last[i] = 1'b0;
                    chk((i == 0) ? "rst0" : "rst1", obs(i), 32'h0);
                end else begin
                    sw   = (i == 0) ? SW0 : SW1;
                    d    = (i == 0) ? D0 : D1;
                    dv   = n[i] % d;
                    b    = (n[i] / d) % (2 * sw);
                    ld   = (dv == d - 1) && (b == 2 * sw - 1);
                    i2s  = (cur_f[i] == 2'd0);
                    left = (b < sw);
                    if (!i2s)
                        sd = model_bit(sw, cur_l[i], cur_r[i], cur_f[i], b);
                    else if (b == 0)
                        sd = prev_last[i];
                    else
                        sd = model_bit(sw, cur_l[i], cur_r[i], cur_f[i], b - 1);
                    exp = {27'b0, ld, ld && !tb_valid, (dv >= d / 2), left ^ i2s, sd};
                    chk((i == 0) ? "pins0" : "pins1", obs(i), exp);
                    if (ld) begin
                        prev_last[i] = model_bit(sw, cur_l[i], cur_r[i], cur_f[i], 2 * sw - 1);
                        cur_l[i]     = tb_valid ? tb_l : '0;
                        cur_r[i]     = tb_valid ? tb_r : '0;
                        cur_f[i]     = (tb_fmt == 2'd3) ? 2'd0 : tb_fmt;
                    end
                    n[i]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic randomize_inputs();
        tb_l     = 16'($urandom);
        tb_r     = 16'($urandom);
        tb_valid = ($urandom_range(0, 9) != 0);
        tb_fmt   = 2'($urandom);
    endtask

    initial begin
        int cnt;
        rst_n    = 1'b0;
        tb_l     = 16'hF0F0;
        tb_r     = 16'h0F0F;
        tb_valid = 1'b1;
        tb_fmt   = 2'd0;
        repeat (4) step();
        rst_n = 1'b1;
        repeat (800) step();
        tb_fmt = 2'd1;
        repeat (800) step();
        tb_l   = 16'h8001;
        tb_fmt = 2'd2;
        repeat (800) step();
        tb_fmt = 2'd1;
        repeat (800) step();
        tb_valid = 1'b0;
        repeat (400) step();
        tb_valid = 1'b1;
        repeat (137) step();
        tb_fmt = 2'd0;
        repeat (800) step();
        for (int k = 0; k < 3000; k++) begin
            step();
            randomize_inputs();
        end

        repeat (37) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst0", obs(0), 32'h0);
        chk("async_rst1", obs(1), 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus1.o_load && cnt < 1000);
        chk("first_load", 32'(cnt), 32'(2 * SW1 * D1 - 1));

        for (int k = 0; k < 1000; k++) begin
            step();
            randomize_inputs();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
